// File: rtl/rvc_asap_5pl_vga_fill_engine_if.sv
// Write-port and fill-command bundle between the core, the fill engine and the VGA controller.
// The slave modport is the engine side; the master modport is the core/controller side.
interface rvc_asap_5pl_vga_fill_engine_if #(
    parameter int unsigned ADDR_W = 14
);
    logic [31:0]       CoreRegRdData2;
    logic [31:0]       CoreAluOut;
    logic [3:0]        CoreVGAMemByteEn;
    logic              CoreVGAMemWrEn;
    logic              CmdValid;
    logic              CmdReady;
    logic [ADDR_W-1:0] CmdStartWord;
    logic [ADDR_W-1:0] CmdLenWords;
    logic [31:0]       CmdPattern;
    logic              CmdAbort;
    logic              Busy;
    logic              Done;
    logic              Err;
    logic [31:0]       RegRdData2;
    logic [31:0]       AluOut;
    logic [3:0]        CtrlVGAMemByteEn;
    logic              CtrlVGAMemWrEn;

    modport master (
        output CoreRegRdData2, CoreAluOut, CoreVGAMemByteEn, CoreVGAMemWrEn,
        output CmdValid, CmdStartWord, CmdLenWords, CmdPattern, CmdAbort,
        input  CmdReady, Busy, Done, Err,
        input  RegRdData2, AluOut, CtrlVGAMemByteEn, CtrlVGAMemWrEn
    );

    modport slave (
        input  CoreRegRdData2, CoreAluOut, CoreVGAMemByteEn, CoreVGAMemWrEn,
        input  CmdValid, CmdStartWord, CmdLenWords, CmdPattern, CmdAbort,
        output CmdReady, Busy, Done, Err,
        output RegRdData2, AluOut, CtrlVGAMemByteEn, CtrlVGAMemWrEn
    );
endinterface

// File: rtl/rvc_asap_5pl_vga_fill_engine.sv
// Frame-buffer fill engine merged with core stores onto the VGA-memory write port.
// Core stores always own the port; the engine writes one pattern word per idle slot.
module rvc_asap_5pl_vga_fill_engine #(
    parameter logic [31:0] VGA_BASE  = 32'h00FF_0000,
    parameter int unsigned VGA_WORDS = 9600,
    parameter int unsigned ADDR_W    = 14
) (
    input  logic                                 CLK_50,
    input  logic                                 Reset_N,
    rvc_asap_5pl_vga_fill_engine_if.slave        bus
);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    localparam logic [ADDR_W:0] MaxEnd = (ADDR_W+1)'(VGA_WORDS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [31:0]       pattern_q, pattern_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   end_sum;
    logic              slot;

    // One extra bit so start+len cannot overflow before the range check.
    assign end_sum = {1'b0, bus.CmdStartWord} + {1'b0, bus.CmdLenWords};
    assign slot    = (state_q == StFill) && !bus.CoreVGAMemWrEn && !bus.CmdAbort;

    always_ff @(posedge CLK_50 or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            remain_q  <= '0;
            pattern_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            pattern_q <= pattern_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        pattern_d = pattern_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (bus.CmdValid && ready_q) begin
                    if (bus.CmdLenWords == '0) begin
                        ready_d = 1'b0;
                        state_d = StDone;
                    end else if (end_sum > MaxEnd) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d    = bus.CmdStartWord;
                        remain_d  = bus.CmdLenWords;
                        pattern_d = bus.CmdPattern;
                        ready_d   = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = StFill;
                    end
                end
            end
            StFill: begin
                if (bus.CmdAbort) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else if (slot) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - ADDR_W'(1);
                    if (remain_q == ADDR_W'(1)) begin
                        busy_d  = 1'b0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.RegRdData2       = '0;
        bus.AluOut           = '0;
        bus.CtrlVGAMemByteEn = '0;
        bus.CtrlVGAMemWrEn   = 1'b0;
        if (bus.CoreVGAMemWrEn) begin
            bus.RegRdData2       = bus.CoreRegRdData2;
            bus.AluOut           = bus.CoreAluOut;
            bus.CtrlVGAMemByteEn = bus.CoreVGAMemByteEn;
            bus.CtrlVGAMemWrEn   = 1'b1;
        end else if (slot) begin
            bus.RegRdData2       = pattern_q;
            bus.AluOut           = VGA_BASE + {{(30-ADDR_W){1'b0}}, addr_q, 2'b00};
            bus.CtrlVGAMemByteEn = 4'hF;
            bus.CtrlVGAMemWrEn   = 1'b1;
        end
    end

    assign bus.CmdReady = ready_q;
    assign bus.Busy     = busy_q;
    assign bus.Err      = err_q;
    // An abort in the completion cycle swallows the pulse.
    assign bus.Done     = (state_q == StDone) && !bus.CmdAbort;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_fill_engine.sv
// Bench for the VGA fill engine: directed scenarios plus random traffic checked every cycle
// against a queue-based model of the pending fill words.
module tb_rvc_asap_5pl_vga_fill_engine;

    localparam logic [31:0] Base  = 32'h00FF_0000;
    localparam int          Words = 9600;

    logic CLK_50  = 1'b0;
    logic Reset_N = 1'b0;

    rvc_asap_5pl_vga_fill_engine_if #(.ADDR_W(14)) bus ();

    rvc_asap_5pl_vga_fill_engine #(
        .VGA_BASE  (Base),
        .VGA_WORDS (Words),
        .ADDR_W    (14)
    ) dut (
        .CLK_50  (CLK_50),
        .Reset_N (Reset_N),
        .bus     (bus)
    );

    always #10 CLK_50 = ~CLK_50;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: words still owed by the active fill, in write order.
    int          m_q[$];
    logic [31:0] m_pat;
    bit          m_active, m_done, m_err, m_ready;

    // Per-scenario observation log.
    int          cyc;
    int          wr_cyc[$];
    logic [31:0] wr_addr[$];
    int          done_cyc, err_cyc, busy_cnt;
    bit          rdy_hist[64];

    function automatic void chk(string name, longint act, longint exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 0;
        m_done   = 0;
        m_err    = 0;
        m_ready  = 0;
    endtask

    task automatic idle_inputs();
        bus.CoreRegRdData2   = '0;
        bus.CoreAluOut       = '0;
        bus.CoreVGAMemByteEn = '0;
        bus.CoreVGAMemWrEn   = 1'b0;
        bus.CmdValid         = 1'b0;
        bus.CmdStartWord     = '0;
        bus.CmdLenWords      = '0;
        bus.CmdPattern       = '0;
        bus.CmdAbort         = 1'b0;
    endtask

    // Inputs are already driven; check at negedge, advance the model at posedge.
    task automatic cycle();
        logic [31:0] e_d, e_a;
        logic [3:0]  e_be;
        logic        e_we;
        bit          n_err;
        int          st, ln;
        @(negedge CLK_50);
        if (bus.CoreVGAMemWrEn) begin
            e_d = bus.CoreRegRdData2; e_a = bus.CoreAluOut;
            e_be = bus.CoreVGAMemByteEn; e_we = 1'b1;
        end else if (m_active && !bus.CmdAbort) begin
            e_d = m_pat; e_a = Base + 32'(m_q[0]) * 4; e_be = 4'hF; e_we = 1'b1;
        end else begin
            e_d = '0; e_a = '0; e_be = '0; e_we = 1'b0;
        end
        chk("wr_en", bus.CtrlVGAMemWrEn, e_we);
        chk("byte_en", bus.CtrlVGAMemByteEn, e_be);
        chk("alu_out", bus.AluOut, e_a);
        chk("wr_data", bus.RegRdData2, e_d);
        chk("busy", bus.Busy, m_active);
        chk("done", bus.Done, m_done && !bus.CmdAbort);
        chk("err", bus.Err, m_err);
        chk("cmd_ready", bus.CmdReady, m_ready);
        if (bus.CtrlVGAMemWrEn && !bus.CoreVGAMemWrEn) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(bus.AluOut);
        end
        if (bus.Done && done_cyc < 0) done_cyc = cyc;
        if (bus.Err && err_cyc < 0) err_cyc = cyc;
        if (bus.Busy) busy_cnt++;
        if (cyc >= 0 && cyc < 64) rdy_hist[cyc] = bus.CmdReady;

        @(posedge CLK_50);
        n_err = 0;
        st = int'(bus.CmdStartWord);
        ln = int'(bus.CmdLenWords);
        if (m_done) begin
            m_done  = 0;
            m_ready = 1;
        end else if (m_active) begin
            if (bus.CmdAbort) begin
                m_q.delete();
                m_active = 0;
                m_ready  = 1;
            end else if (!bus.CoreVGAMemWrEn) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else if (bus.CmdValid && m_ready) begin
            if (ln == 0) begin
                m_done  = 1;
                m_ready = 0;
            end else if (st + ln > Words) begin
                n_err = 1;
            end else begin
                for (int k = 0; k < ln; k++) m_q.push_back(st + k);
                m_pat    = bus.CmdPattern;
                m_active = 1;
                m_ready  = 0;
            end
        end else begin
            m_ready = 1;
        end
        m_err = n_err;
        #1;
    endtask

    task automatic run_cmd(int start, int len, logic [31:0] pat, int core_c, int abort_c,
                           int extra_c, int n);
        wr_cyc.delete();
        wr_addr.delete();
        done_cyc = -1;
        err_cyc  = -1;
        busy_cnt = 0;
        for (int c = 0; c <= n; c++) begin
            cyc = c;
            idle_inputs();
            if (c == 0) begin
                bus.CmdValid     = 1'b1;
                bus.CmdStartWord = 14'(start);
                bus.CmdLenWords  = 14'(len);
                bus.CmdPattern   = pat;
            end else if (c == extra_c) begin
                bus.CmdValid     = 1'b1;
                bus.CmdStartWord = 14'd0;
                bus.CmdLenWords  = 14'd1;
                bus.CmdPattern   = 32'hDEAD_BEEF;
            end
            if (c == core_c) begin
                bus.CoreVGAMemWrEn   = 1'b1;
                bus.CoreAluOut       = 32'h00FF_1000;
                bus.CoreRegRdData2   = 32'h1234_5678;
                bus.CoreVGAMemByteEn = 4'h3;
            end
            bus.CmdAbort = (c == abort_c);
            cycle();
        end
        idle_inputs();
        cyc = -1;
    endtask

    task automatic release_reset(string tag);
        @(posedge CLK_50);
        #1 Reset_N = 1'b1;
        chk({tag, "_ready_pre"}, bus.CmdReady, 0);
        cyc = -1;
        cycle();
        chk({tag, "_ready_post"}, bus.CmdReady, 1);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        cyc = -1;
        repeat (3) @(posedge CLK_50);
        release_reset("rst0");

        // Reset mid-fill drops everything at once.
        run_cmd(0, 50, 32'hA5A5_A5A5, -1, -1, -1, 3);
        #2 Reset_N = 1'b0;
        #1;
        model_reset();
        chk("rst_wr_en", bus.CtrlVGAMemWrEn, 0);
        chk("rst_alu_out", bus.AluOut, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_ready", bus.CmdReady, 0);
        chk("rst_done_err", {bus.Done, bus.Err}, 0);
        repeat (2) @(posedge CLK_50);
        release_reset("rst1");

        // Basic 4-word fill, core silent.
        run_cmd(0, 4, 32'hFFFF_FFFF, -1, -1, -1, 7);
        chk("t2_nwr", wr_addr.size(), 4);
        for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
            chk("t2_addr", wr_addr[i], 32'h00FF_0000 + 32'(i * 4));
            chk("t2_wcyc", wr_cyc[i], i + 1);
        end
        chk("t2_done_cyc", done_cyc, 5);
        chk("t2_busy_cycles", busy_cnt, 4);

        // Core store in the 2nd fill cycle stalls the engine one slot.
        run_cmd(0, 4, 32'hFFFF_FFFF, 2, -1, -1, 8);
        chk("t3_nwr", wr_addr.size(), 4);
        if (wr_addr.size() >= 2) begin
            chk("t3_resume_addr", wr_addr[1], 32'h00FF_0004);
            chk("t3_resume_cyc", wr_cyc[1], 3);
        end
        chk("t3_done_cyc", done_cyc, 6);

        // Range end: last legal word, then one past.
        run_cmd(9598, 2, 32'h0F0F_0F0F, -1, -1, -1, 5);
        chk("t4_nwr", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            chk("t4_addr0", wr_addr[0], 32'h00FF_95F8);
            chk("t4_addr1", wr_addr[1], 32'h00FF_95FC);
        end
        chk("t4_done_cyc", done_cyc, 3);
        run_cmd(9599, 2, 32'h0F0F_0F0F, -1, -1, -1, 3);
        chk("t4_err_nwr", wr_addr.size(), 0);
        chk("t4_err_cyc", err_cyc, 1);
        chk("t4_err_nodone", done_cyc, -1);

        // Zero length, then a command offered mid-fill.
        run_cmd(0, 0, 32'h1111_1111, -1, -1, -1, 3);
        chk("t5_len0_nwr", wr_addr.size(), 0);
        chk("t5_len0_done", done_cyc, 1);
        chk("t5_len0_busy", busy_cnt, 0);
        run_cmd(10, 5, 32'h2222_2222, -1, -1, 2, 8);
        chk("t5_nwr", wr_addr.size(), 5);
        if (wr_addr.size() == 5) chk("t5_last_addr", wr_addr[4], 32'h00FF_0038);
        chk("t5_done_cyc", done_cyc, 6);

        // Abort after 10 words.
        run_cmd(100, 80, 32'h3333_3333, -1, 11, -1, 13);
        chk("t6_nwr", wr_addr.size(), 10);
        if (wr_addr.size() == 10) chk("t6_last_addr", wr_addr[9], 32'h00FF_01B4);
        chk("t6_nodone", done_cyc, -1);
        chk("t6_ready_abort_cyc", rdy_hist[11], 0);
        chk("t6_ready_after", rdy_hist[12], 1);

        // Random traffic against the model.
        done_cyc = -1;
        err_cyc  = -1;
        for (int i = 0; i < 2500; i++) begin
            int st, ln;
            idle_inputs();
            if ($urandom % 16 == 0)     st = int'($urandom % 16384);
            else if ($urandom % 2 == 0) st = int'($urandom_range(9599, 9550));
            else                        st = int'($urandom_range(9599, 0));
            ln = ($urandom % 8 == 0) ? 0 : int'($urandom_range(60, 1));
            bus.CmdValid     = ($urandom % 4 == 0);
            bus.CmdStartWord = 14'(st);
            bus.CmdLenWords  = 14'(ln);
            bus.CmdPattern   = $urandom;
            bus.CoreVGAMemWrEn   = ($urandom % 3 == 0);
            bus.CoreAluOut       = $urandom;
            bus.CoreRegRdData2   = $urandom;
            bus.CoreVGAMemByteEn = 4'($urandom);
            bus.CmdAbort         = ($urandom % 25 == 0);
            cycle();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
